// File: rtl/aoc_pkg.sv
// aoc_pkg: shared ASCII constants, parser state encoding and digit classifier
package aoc_pkg;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef RX_NUMBER_PARSER_SIGNED_EN
    NEG   = 2'd2,
`endif
    ACCUM = 2'd1
  } state_t;
  function automatic logic is_digit(input logic [7:0] b);
    return b >= CH_0 && b <= CH_9;
  endfunction
endpackage

// File: rtl/rx_number_parser_dec_mac.sv
// dec_mac: combinational acc*10+digit with carry-out overflow detection
module dec_mac #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [3:0]       digit,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);
  logic [WIDTH+3:0] ext, wide;
  assign ext  = {4'b0, acc};
  assign wide = (ext << 3) + (ext << 1) + {{WIDTH{1'b0}}, digit};
  assign sum  = wide[WIDTH-1:0];
  assign ovf  = |wide[WIDTH+3:WIDTH];
endmodule

// File: rtl/rx_number_parser.sv
// rx_number_parser: UART byte stream to decimal-number records over valid/ready.
// Define RX_NUMBER_PARSER_SIGNED_EN to accept a leading '-' and emit two's-complement values.
module rx_number_parser
  import aoc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_avail,
  input  logic [7:0]       rx_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_eol,
  output logic             out_blank,
  output logic             out_overflow,
  output logic             dropped
);
  state_t state, state_n;
  logic [WIDTH-1:0] acc, acc_n, mac_sum, em_val;
  logic ovf, ovf_n, mac_ovf, prev_lf, prev_lf_n;
  logic emit, em_eol, em_blank, em_ovf;
  logic dig, lf;
  assign dig = is_digit(rx_data);
  assign lf  = rx_data == CH_LF;
  dec_mac #(.WIDTH(WIDTH)) u_mac (
    .acc  (acc),
    .digit(rx_data[3:0]),
    .sum  (mac_sum),
    .ovf  (mac_ovf)
  );
`ifdef RX_NUMBER_PARSER_SIGNED_EN
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
  logic neg, neg_n;
  assign em_val = em_blank ? '0 : (neg_n ? '0 - acc_n : acc_n);
  assign em_ovf = !em_blank && (ovf_n || (neg_n ? acc_n > HALF : acc_n[WIDTH-1]));
`else
  assign em_val = em_blank ? '0 : acc_n;
  assign em_ovf = !em_blank && ovf_n;
`endif
  // State, accumulator and previous-LF tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      acc     <= '0;
      ovf     <= 1'b0;
      prev_lf <= 1'b0;
`ifdef RX_NUMBER_PARSER_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      ovf     <= ovf_n;
      prev_lf <= prev_lf_n;
`ifdef RX_NUMBER_PARSER_SIGNED_EN
      neg     <= neg_n;
`endif
    end
  end
  // Byte handling first, then flush terminates whatever number the byte left open
  always_comb begin
    state_n   = state;
    acc_n     = acc;
    ovf_n     = ovf;
    prev_lf_n = prev_lf;
    emit      = 1'b0;
    em_eol    = 1'b0;
    em_blank  = 1'b0;
`ifdef RX_NUMBER_PARSER_SIGNED_EN
    neg_n     = neg;
`endif
    if (rx_avail) begin
      prev_lf_n = lf;
      case (state)
        IDLE:
          if (dig) begin
            state_n = ACCUM;
            acc_n   = WIDTH'(rx_data[3:0]);
            ovf_n   = 1'b0;
`ifdef RX_NUMBER_PARSER_SIGNED_EN
            neg_n   = 1'b0;
          end else if (rx_data == CH_MINUS) begin
            state_n = NEG;
`endif
          end else if (lf && prev_lf) begin
            emit     = 1'b1;
            em_blank = 1'b1;
            em_eol   = 1'b1;
          end
        ACCUM:
          if (dig) begin
            acc_n = mac_sum;
            ovf_n = ovf | mac_ovf;
          end else begin
            emit    = 1'b1;
            em_eol  = lf;
            state_n = IDLE;
          end
`ifdef RX_NUMBER_PARSER_SIGNED_EN
        NEG:
          if (dig) begin
            state_n = ACCUM;
            acc_n   = WIDTH'(rx_data[3:0]);
            ovf_n   = 1'b0;
            neg_n   = 1'b1;
          end else begin
            state_n = IDLE;
          end
`endif
        default: state_n = IDLE;
      endcase
    end
    if (flush && state_n == ACCUM) begin
      emit    = 1'b1;
      em_eol  = 1'b0;
      state_n = IDLE;
    end
  end
  // Single-entry output register; records emitted while it is full are lost and flagged
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_value    <= '0;
      out_eol      <= 1'b0;
      out_blank    <= 1'b0;
      out_overflow <= 1'b0;
      dropped      <= 1'b0;
    end else if (emit && (!out_valid || out_ready)) begin
      out_valid    <= 1'b1;
      out_value    <= em_val;
      out_eol      <= em_eol;
      out_blank    <= em_blank;
      out_overflow <= em_ovf;
    end else if (emit) begin
      dropped      <= 1'b1;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rx_number_parser.sv
// tb_rx_number_parser: directed byte-stream vectors against 32-bit and 8-bit parsers
module tb_rx_number_parser;
`ifdef RX_NUMBER_PARSER_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  logic clk = 0, reset = 0, rx_avail = 0, flush = 0, out_ready = 0;
  logic [7:0] rx_data = 0;
  logic out_valid, out_eol, out_blank, out_overflow, dropped;
  logic [31:0] out_value;
  logic v8, eol8, blank8, ovf8, drop8;
  logic [7:0] val8;
  int n_cmp = 0, n_bad = 0;
  always #20 clk = ~clk;
  rx_number_parser #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .rx_avail(rx_avail), .rx_data(rx_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value), .out_eol(out_eol),
    .out_blank(out_blank), .out_overflow(out_overflow), .dropped(dropped)
  );
  rx_number_parser #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .rx_avail(rx_avail), .rx_data(rx_data), .flush(flush),
    .out_valid(v8), .out_ready(out_ready), .out_value(val8), .out_eol(eol8),
    .out_blank(blank8), .out_overflow(ovf8), .dropped(drop8)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic chk_rec(input string tag, input logic [31:0] v, input logic eol, input logic blank, input logic ovf);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_value"}, out_value, v);
    chk({tag, "_eol"}, 32'(out_eol), 32'(eol));
    chk({tag, "_blank"}, 32'(out_blank), 32'(blank));
    chk({tag, "_ovf"}, 32'(out_overflow), 32'(ovf));
  endtask
  task automatic put(input logic [7:0] b, input logic f);
    rx_avail = 1; rx_data = b; flush = f;
    @(negedge clk);
    rx_avail = 0; flush = 0;
  endtask
  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) put(s.getc(i), 1'b0);
  endtask
  task automatic pulse_flush();
    flush = 1;
    @(negedge clk);
    flush = 0;
  endtask
  initial begin
    #5;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_value", out_value, 0);
    chk("rst_dropped", 32'(dropped), 0);
    repeat (2) @(negedge clk);
    reset = 1; out_ready = 1;
    send("123");
    chk("t1_pre", 32'(out_valid), 0);
    put(8'h0A, 0);
    chk_rec("t1", 123, 1, 0, 0);
    @(negedge clk);
    chk("t1_drop_valid", 32'(out_valid), 0);
    out_ready = 0;
    send("7,");
    chk_rec("t2_7", 7, 0, 0, 0);
    send("42 ");
    chk("t2_hold_valid", 32'(out_valid), 1);
    chk("t2_hold_value", out_value, 7);
    chk("t2_dropped", 32'(dropped), 1);
    @(negedge clk);
    chk("t2_still7", out_value, 7);
    out_ready = 1;
    @(negedge clk);
    chk("t2_accept", 32'(out_valid), 0);
    send("5\n");
    chk_rec("t3_5", 5, 1, 0, 0);
    put(8'h0A, 0);
    chk_rec("t3_blank", 0, 1, 1, 0);
    send("9\n");
    chk_rec("t3_9", 9, 1, 0, 0);
    send("300\n");
    chk("t4_w8_val", 32'(val8), 44);
    chk("t4_w8_ovf", 32'(ovf8), 1);
    chk_rec("t4_w32", 300, 1, 0, 0);
    send("12\n");
    chk("t4_12_val", 32'(val8), 12);
    chk("t4_12_ovf", 32'(ovf8), 0);
    send("255\n");
    chk("t4_255_val", 32'(val8), 255);
    chk("t4_255_ovf", 32'(ovf8), 32'(SGN));
    send("256\n");
    chk("t4_256_val", 32'(val8), 0);
    chk("t4_256_ovf", 32'(ovf8), 1);
    send("128\n");
    chk("t4_128_val", 32'(val8), 128);
    chk("t4_128_ovf", 32'(ovf8), 32'(SGN));
    send("88");
    pulse_flush();
    chk_rec("t5_88", 88, 0, 0, 0);
    send("1");
    put("6", 1);
    chk_rec("t5_16", 16, 0, 0, 0);
    pulse_flush();
    chk("t5_idle_flush", 32'(out_valid), 0);
    out_ready = 0;
    send("9 ");
    chk("t5_held", 32'(out_valid), 1);
    chk("t5_drop_pre", 32'(dropped), 1);
    send("4");
    #5 reset = 0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 0);
    chk("t5_rst_value", out_value, 0);
    chk("t5_rst_eol", 32'(out_eol), 0);
    chk("t5_rst_dropped", 32'(dropped), 0);
    @(negedge clk);
    reset = 1;
    put(8'h0A, 0);
    chk("t5_no_rec", 32'(out_valid), 0);
    out_ready = 1;
    send("-15\n");
    chk_rec("t6_m15", SGN ? 32'hFFFF_FFF1 : 32'd15, 1, 0, 0);
    send("- ");
    chk("t6_no_rec", 32'(out_valid), 0);
    send("3\n");
    chk_rec("t6_3", 3, 1, 0, 0);
    send("-128\n");
    chk("t6_m128_val", 32'(val8), 128);
    chk("t6_m128_ovf", 32'(ovf8), 0);
    send("-129\n");
    chk("t6_m129_val", 32'(val8), SGN ? 127 : 129);
    chk("t6_m129_ovf", 32'(ovf8), 32'(SGN));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
